// File: rtl/fifo_pop_streamer.sv
// Pop-side controller: drains LEN operands from a show-ahead FIFO into one skewed PE-array edge row.
// Optional build macro FIFO_STREAM_STATS_EN adds a saturating underrun counter output.
module fifo_pop_streamer #(
  parameter int unsigned BWIDTH = 8,
  parameter int unsigned SKEW   = 0,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic              FIFO_EMPTY,
  input  logic [BWIDTH-1:0] FIFO_DOUT,
  output logic              FIFO_POPE,
  input  logic              PE_STALL,
  output logic [BWIDTH-1:0] PE_DATA,
  output logic              PE_VALID,
  output logic              BUSY,
  output logic              DONE
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [15:0]       UNDERRUN_CNT
`endif
);

  localparam int unsigned DEPTH = SKEW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              zdone_q, zdone_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [BWIDTH-1:0] dat_q [DEPTH];
  logic [BWIDTH-1:0] dat_d [DEPTH];
  logic              pop;
  logic              start_ok;
  logic              flush_done;

  // Next-state, skew pipeline shift and pop/done strobes; a stall freezes everything.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    zdone_d    = 1'b0;
    vld_d      = vld_q;
    dat_d      = dat_q;
    start_ok   = 1'b0;
    flush_done = 1'b0;
    pop        = (state_q == S_STREAM) & ~FIFO_EMPTY & ~PE_STALL &
                 (rem_q != '0) & ~RST;

    if (!PE_STALL) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
      vld_d[0] = pop;
      dat_d[0] = pop ? FIFO_DOUT : '0;

      case (state_q)
        S_IDLE: begin
          if (START) begin
            start_ok = 1'b1;
            if (LEN != '0) begin
              state_d = S_STREAM;
              rem_d   = LEN;
            end else begin
              zdone_d = 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (pop) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (vld_q == '0) begin
            flush_done = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    FIFO_POPE = pop;
    DONE      = ~RST & (zdone_q | flush_done);
    BUSY      = (state_q != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      zdone_q <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      zdone_q <= zdone_d;
      vld_q   <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) dat_q[i] <= dat_d[i];
    end
  end

  assign PE_DATA  = dat_q[DEPTH-1];
  assign PE_VALID = vld_q[DEPTH-1];

`ifdef FIFO_STREAM_STATS_EN
  logic [15:0] urun_q, urun_d;

  // Counts starved streaming cycles; restarts with every accepted tile.
  always_comb begin
    urun_d = urun_q;
    if (start_ok) begin
      urun_d = '0;
    end else if ((state_q == S_STREAM) && FIFO_EMPTY && !PE_STALL &&
                 (rem_q != '0) && (urun_q != 16'hFFFF)) begin
      urun_d = urun_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) urun_q <= '0;
    else     urun_q <= urun_d;
  end

  assign UNDERRUN_CNT = urun_q;
`endif

endmodule
